// File: rtl/axi_dma_cmd_arb_if.sv
// Command bus for axi_dma_cmd_arb: per-channel command inputs plus the
// write-master and read-master command ports.
// master modport: the arbiter itself; slave modport: channels and DMA masters.
interface axi_dma_cmd_arb_if #(
   parameter int unsigned NUM_CH      = 4,
   parameter int unsigned AXI_ID_WD   = 2,
   parameter int unsigned AXI_ADDR_WD = 32
);
   logic [NUM_CH-1:0]             ch_cmd_valid;
   logic [NUM_CH-1:0]             ch_cmd_dir;
   logic [NUM_CH*AXI_ADDR_WD-1:0] ch_cmd_addr;
   logic [NUM_CH*2-1:0]           ch_cmd_burst;
   logic [NUM_CH*3-1:0]           ch_cmd_size;
   logic [NUM_CH*AXI_ADDR_WD-1:0] ch_cmd_len;
   logic [NUM_CH-1:0]             ch_cmd_ready;
   logic [NUM_CH-1:0]             ch_cmd_abort;

   logic                   w_cmd_valid;
   logic [AXI_ADDR_WD-1:0] w_cmd_addr;
   logic [AXI_ID_WD-1:0]   w_cmd_id;
   logic [1:0]             w_cmd_burst;
   logic [2:0]             w_cmd_size;
   logic [AXI_ADDR_WD-1:0] w_cmd_len;
   logic                   w_cmd_ready;
   logic                   w_cmd_abort;

   logic                   r_cmd_valid;
   logic [AXI_ADDR_WD-1:0] r_cmd_addr;
   logic [AXI_ID_WD-1:0]   r_cmd_id;
   logic [1:0]             r_cmd_burst;
   logic [2:0]             r_cmd_size;
   logic [AXI_ADDR_WD-1:0] r_cmd_len;
   logic                   r_cmd_ready;
   logic                   r_cmd_abort;

   modport master (
      input  ch_cmd_valid, ch_cmd_dir, ch_cmd_addr, ch_cmd_burst, ch_cmd_size, ch_cmd_len,
      output ch_cmd_ready, ch_cmd_abort,
      output w_cmd_valid, w_cmd_addr, w_cmd_id, w_cmd_burst, w_cmd_size, w_cmd_len,
      input  w_cmd_ready, w_cmd_abort,
      output r_cmd_valid, r_cmd_addr, r_cmd_id, r_cmd_burst, r_cmd_size, r_cmd_len,
      input  r_cmd_ready, r_cmd_abort
   );

   modport slave (
      output ch_cmd_valid, ch_cmd_dir, ch_cmd_addr, ch_cmd_burst, ch_cmd_size, ch_cmd_len,
      input  ch_cmd_ready, ch_cmd_abort,
      input  w_cmd_valid, w_cmd_addr, w_cmd_id, w_cmd_burst, w_cmd_size, w_cmd_len,
      output w_cmd_ready, w_cmd_abort,
      input  r_cmd_valid, r_cmd_addr, r_cmd_id, r_cmd_burst, r_cmd_size, r_cmd_len,
      output r_cmd_ready, r_cmd_abort
   );
endinterface

// File: rtl/axi_dma_cmd_arb.sv
// N-channel DMA command front end. Two independent round-robin arbiters
// (read and write) each grant one channel, register its command and present
// it to the matching master with AXI ID = channel index. Downstream aborts
// are returned to the owning channel as a one-cycle pulse.
// Optional: define CMD_LEN_CHECK_EN to accept-and-reject zero-length commands
// instead of forwarding them.
module axi_dma_cmd_arb #(
   parameter int unsigned NUM_CH      = 4,
   parameter int unsigned AXI_ID_WD   = 2,
   parameter int unsigned AXI_ADDR_WD = 32
) (
   input  logic              AXI_ACLK,
   input  logic              AXI_ARESETN,
   axi_dma_cmd_arb_if.master cmd
);
   localparam int unsigned PTR_W = $clog2(NUM_CH);

   localparam logic [0:0] IDLE  = 1'b0;
   localparam logic [0:0] ISSUE = 1'b1;

   logic [AXI_ADDR_WD-1:0] ch_addr  [NUM_CH];
   logic [AXI_ADDR_WD-1:0] ch_len   [NUM_CH];
   logic [1:0]             ch_burst [NUM_CH];
   logic [2:0]             ch_size  [NUM_CH];

   // index 0 = read arbiter, index 1 = write arbiter
   logic [NUM_CH-1:0] rdy_all   [2];
   logic [NUM_CH-1:0] abort_all [2];

   for (genvar i = 0; i < NUM_CH; i++) begin : g_unpack
      assign ch_addr[i]  = cmd.ch_cmd_addr[i*AXI_ADDR_WD +: AXI_ADDR_WD];
      assign ch_len[i]   = cmd.ch_cmd_len[i*AXI_ADDR_WD +: AXI_ADDR_WD];
      assign ch_burst[i] = cmd.ch_cmd_burst[i*2 +: 2];
      assign ch_size[i]  = cmd.ch_cmd_size[i*3 +: 3];
   end

   // (p + k) mod NUM_CH for p, k < NUM_CH; works for non-power-of-2 NUM_CH
   function automatic logic [PTR_W-1:0] wrap_add(input logic [PTR_W-1:0] p,
                                                 input int unsigned k);
      int unsigned s;
      s = 32'(p) + k;
      if (s >= NUM_CH) s = s - NUM_CH;
      return PTR_W'(s);
   endfunction

   for (genvar d = 0; d < 2; d++) begin : g_arb
      logic [NUM_CH-1:0]      req, rdy, abort_d, abort_q;
      logic [0:0]             state_d, state_q;
      logic [PTR_W-1:0]       ptr_d, ptr_q, gnt_d, gnt_q, sel;
      logic                   found;
      logic [AXI_ADDR_WD-1:0] addr_d, addr_q, len_d, len_q;
      logic [1:0]             burst_d, burst_q;
      logic [2:0]             size_d, size_q;
      logic                   down_ready, down_abort;

      if (d == 1) begin : g_w
         assign req             = cmd.ch_cmd_valid & cmd.ch_cmd_dir;
         assign down_ready      = cmd.w_cmd_ready;
         assign down_abort      = cmd.w_cmd_abort;
         assign cmd.w_cmd_valid = (state_q == ISSUE);
         assign cmd.w_cmd_addr  = addr_q;
         assign cmd.w_cmd_id    = AXI_ID_WD'(gnt_q);
         assign cmd.w_cmd_burst = burst_q;
         assign cmd.w_cmd_size  = size_q;
         assign cmd.w_cmd_len   = len_q;
      end else begin : g_r
         assign req             = cmd.ch_cmd_valid & ~cmd.ch_cmd_dir;
         assign down_ready      = cmd.r_cmd_ready;
         assign down_abort      = cmd.r_cmd_abort;
         assign cmd.r_cmd_valid = (state_q == ISSUE);
         assign cmd.r_cmd_addr  = addr_q;
         assign cmd.r_cmd_id    = AXI_ID_WD'(gnt_q);
         assign cmd.r_cmd_burst = burst_q;
         assign cmd.r_cmd_size  = size_q;
         assign cmd.r_cmd_len   = len_q;
      end

      assign rdy_all[d]   = rdy;
      assign abort_all[d] = abort_q;

      // Round-robin search: first requester at or after the pointer, with wrap
      always_comb begin
         found = 1'b0;
         sel   = '0;
         for (int unsigned k = 0; k < NUM_CH; k++) begin
            if (!found && req[wrap_add(ptr_q, k)]) begin
               found = 1'b1;
               sel   = wrap_add(ptr_q, k);
            end
         end
      end

      // Arbiter next state: grant/capture in IDLE, hold until ready or abort in ISSUE
      always_comb begin
         state_d = state_q;
         ptr_d   = ptr_q;
         gnt_d   = gnt_q;
         addr_d  = addr_q;
         len_d   = len_q;
         burst_d = burst_q;
         size_d  = size_q;
         abort_d = '0;
         rdy     = '0;
         case (state_q)
            IDLE: begin
               if (found) begin
                  rdy[sel] = 1'b1;
                  gnt_d    = sel;
                  addr_d   = ch_addr[sel];
                  len_d    = ch_len[sel];
                  burst_d  = ch_burst[sel];
                  size_d   = ch_size[sel];
`ifdef CMD_LEN_CHECK_EN
                  if (ch_len[sel] == '0) begin
                     abort_d[sel] = 1'b1;
                     ptr_d        = wrap_add(sel, 1);
                  end else begin
                     state_d = ISSUE;
                  end
`else
                  state_d = ISSUE;
`endif
               end
            end
            ISSUE: begin
               // abort wins over a simultaneous ready
               if (down_abort) begin
                  abort_d[gnt_q] = 1'b1;
                  state_d        = IDLE;
                  ptr_d          = wrap_add(gnt_q, 1);
               end else if (down_ready) begin
                  state_d = IDLE;
                  ptr_d   = wrap_add(gnt_q, 1);
               end
            end
            default: state_d = IDLE;
         endcase
      end

      // Arbiter state and registered command fields
      always_ff @(posedge AXI_ACLK or negedge AXI_ARESETN) begin
         if (!AXI_ARESETN) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            gnt_q   <= '0;
            addr_q  <= '0;
            len_q   <= '0;
            burst_q <= '0;
            size_q  <= '0;
            abort_q <= '0;
         end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            burst_q <= burst_d;
            size_q  <= size_d;
            abort_q <= abort_d;
         end
      end
   end

   // ready is combinational from the IDLE grant; forced low while in reset
   assign cmd.ch_cmd_ready = (rdy_all[0] | rdy_all[1]) & {NUM_CH{AXI_ARESETN}};
   assign cmd.ch_cmd_abort = abort_all[0] | abort_all[1];
endmodule

// File: doc/axi_dma_cmd_arb.md
Name: axi_dma_cmd_arb

Overview:
- N-channel command front end for the AXI DMA. Replaces the single shared command port that drives the write and read masters together.
- Each channel presents a tagged read or write command. The block runs independent round-robin arbitration per direction, so one read and one write can be in flight at once.
- It forwards each granted command to the write-master or read-master command port with AXI ID = channel index, and routes downstream aborts back to the owning channel.

Parameters:
NUM_CH, 4, number of command channels (2..16)
AXI_ID_WD, 2, ID width; must be >= clog2(NUM_CH); channel index zero-extended into ID
AXI_ADDR_WD, 32, address and length width

Ports:
AXI_ACLK  in  1  clock
AXI_ARESETN  in  1  asynchronous active-low reset
ch_cmd_valid  in  NUM_CH  per-channel command valid
ch_cmd_dir  in  NUM_CH  0 = read, 1 = write
ch_cmd_addr  in  NUM_CH*AXI_ADDR_WD  start address, channel i at slice i
ch_cmd_burst  in  NUM_CH*2  AXI burst type
ch_cmd_size  in  NUM_CH*3  AXI size
ch_cmd_len  in  NUM_CH*AXI_ADDR_WD  transfer length
ch_cmd_ready  out  NUM_CH  per-channel accept
ch_cmd_abort  out  NUM_CH  one-cycle abort/reject pulse to the owning channel
w_cmd_valid  out  1  write-master command valid
w_cmd_addr / w_cmd_id / w_cmd_burst / w_cmd_size / w_cmd_len  out  AXI_ADDR_WD / AXI_ID_WD / 2 / 3 / AXI_ADDR_WD  write command fields
w_cmd_ready  in  1  write master accepts
w_cmd_abort  in  1  write master aborts the presented command
r_cmd_valid, r_cmd_addr, r_cmd_id, r_cmd_burst, r_cmd_size, r_cmd_len  out  same widths  read command fields
r_cmd_ready  in  1  read master accepts
r_cmd_abort  in  1  read master aborts the presented command

Behaviour:
- Reset (async, AXI_ARESETN low):
  - All outputs 0.
  - Both arbiters enter IDLE.
  - Both round-robin pointers = 0.
  - Any held command is discarded, with no abort pulse.
- Two identical arbiters, W (requests = ch_cmd_valid & ch_cmd_dir) and R (requests = ch_cmd_valid & ~ch_cmd_dir). Each has states IDLE and ISSUE.
- IDLE:
  - If any request is set, grant the first requester at or after the pointer, searching upward with wrap from NUM_CH-1 to 0.
  - ch_cmd_ready[g] is combinational, high for that cycle only.
  - Capture addr/burst/size/len into the output register; id = g.
  - Next state is ISSUE.
  - No request: stay in IDLE, all ready = 0.
- ISSUE:
  - x_cmd_valid = 1; fields held stable.
  - No ch_cmd_ready is asserted by this arbiter.
  - x_cmd_ready = 1: next state IDLE, x_cmd_valid deasserts next cycle, pointer = (g+1) mod NUM_CH.
  - x_cmd_abort = 1: abort has priority over a simultaneous ready. The command is dropped, ch_cmd_abort[g] pulses high the next cycle for one cycle, next state IDLE, pointer = (g+1) mod NUM_CH.
- Latency and throughput:
  - Command handshake at cycle N gives x_cmd_valid at N+1.
  - Minimum 2 cycles per command per direction.
- W and R grant independently in the same cycle. They never grant the same channel, because each channel's request goes to exactly one arbiter.
- ch_cmd_ready and ch_cmd_abort are the OR of both arbiters' contributions.
- A channel may change ch_cmd_dir or its fields only after its handshake; there is no hazard checking.
- Widths: id = channel index zero-extended to AXI_ID_WD. Pointer width = clog2(NUM_CH), wrapping modulo NUM_CH (non-power-of-2 NUM_CH supported).

Optional Feature:
- Macro CMD_LEN_CHECK_EN.
- Defined:
  - In IDLE, a granted command with len == 0 is still accepted (ch_cmd_ready high) but is not forwarded.
  - ch_cmd_abort[g] pulses the next cycle, the arbiter stays in IDLE, and the pointer advances.
  - x_cmd_valid never asserts for that command.
- Not defined: zero-length commands are forwarded unchanged.

Test Plan:
- Reset, then ch0 write addr 0x1000 len 0x40: ch_cmd_ready[0] at cycle N; w_cmd_valid at N+1 with addr 0x1000, id 0, len 0x40. Hold w_cmd_ready low 3 cycles: fields stable. Then ready: valid drops next cycle.
- ch0..ch3 all write-valid continuously, w_cmd_ready tied 1: grant order 0,1,2,3,0; w_cmd_id sequence 0,1,2,3,0; one command every 2 cycles.
- Same cycle, ch1 read 0x2000 and ch2 write 0x3000: ch_cmd_ready = 4'b0110. Next cycle r_cmd_valid (id 1) and w_cmd_valid (id 2) are both high.
- ch3 read issued, r_cmd_abort and r_cmd_ready together: ch_cmd_abort[3] = 1 for exactly one cycle. r_cmd_valid drops. Next read grant goes to ch0 (pointer wrapped).
- AXI_ARESETN pulled low while w_cmd_valid = 1: all outputs 0 immediately. After release, ch2 request is granted first (pointer 0, ch0/ch1 idle).
- With CMD_LEN_CHECK_EN defined, ch1 write len 0: ch_cmd_ready[1] then ch_cmd_abort[1] one cycle later; w_cmd_valid stays 0. Without the macro: forwarded with len 0.
